// File: rtl/muldiv_seq_pkg.sv
// rv32imc_types
// Shared types for the RV32 M-extension sequencer.
//   muldiv_op_t    : M-extension operation, encoded exactly as funct3
//   muldiv_state_t : sequencer states
//   MULDIV_ITERS   : number of radix-2 iterations per operation
package rv32imc_types;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } muldiv_state_t;

    localparam int MULDIV_ITERS = 32;

endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq
// Iterative multiply/divide sequencer for the RV32 M extension, sitting
// beside the execute stage. Multiplies by radix-2 shift-add and divides by
// restoring division, both on operand magnitudes, then applies the sign
// correction in a single FIX cycle.
//
// Ports:
//   clk      : clock, all state changes on the rising edge
//   rst      : synchronous reset, active low
//   i_valid  : EX holds an M-extension op this cycle
//   i_op     : operation (funct3 encoding, see muldiv_op_t)
//   i_a/i_b  : rs1/rs2 operands after forwarding
//   i_kill   : flush, abandon the current op
//   i_hold   : EX stalled by some other source
//   o_stall  : stall request OR-ed into the EX stall
//   o_done   : o_result holds the finished result this cycle
//   o_result : result returned to the EX output mux
module muldiv_seq
    import rv32imc_types::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic            i_kill,
    input  logic            i_hold,
    output logic            o_stall,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return ~v + XLEN'(1);
    endfunction

    muldiv_state_t    state_q, state_nxt;
    muldiv_op_t       op_q;
    logic             neg_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  opnd_q;
    logic [XLEN-1:0]  acc_hi;
    logic [XLEN-1:0]  acc_lo;
    logic [XLEN-1:0]  result_q;

    muldiv_op_t       op_in;
    logic             a_signed, b_signed, neg_a, neg_b, res_neg;
    logic [XLEN-1:0]  a_mag, b_mag;
    logic             div_zero, div_ovf, special;
    logic [XLEN-1:0]  special_res;

    logic [XLEN:0]    mul_sum;
    logic [XLEN:0]    div_shift;
    logic             div_ge;
    logic [XLEN-1:0]  div_diff;
    logic [XLEN-1:0]  lo_fix, hi_fix, fix_res;
    logic             sel_lo;
    logic             last_iter;

    // Decode the incoming op: which operands are signed, their magnitudes,
    // the sign the final result must take, and the divide corner cases that
    // skip the iteration loop entirely.
    always_comb begin
        op_in    = muldiv_op_t'(i_op);
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (op_in)
            MUL, MULH, DIV, REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            MULHSU:  a_signed = 1'b1;
            default: ;
        endcase
        neg_a   = a_signed & i_a[XLEN-1];
        neg_b   = b_signed & i_b[XLEN-1];
        a_mag   = neg_a ? negate(i_a) : i_a;
        b_mag   = neg_b ? negate(i_b) : i_b;
        // A remainder follows the dividend; everything else follows the
        // XOR of the operand signs.
        res_neg = (op_in == REM) ? neg_a : (neg_a ^ neg_b);

        div_zero = i_op[2] && (i_b == '0);
        div_ovf  = ((op_in == DIV) || (op_in == REM)) &&
                   (i_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_b == '1);
        special  = div_zero | div_ovf;
        // i_op[1] separates the remainder ops from the quotient ops.
        if (div_zero)
            special_res = i_op[1] ? i_a : '1;
        else
            special_res = i_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // One iteration step for each algorithm, plus the FIX-cycle sign
    // correction. The multiplier lives in acc_lo and shifts out to the right
    // while the product grows into acc_hi; the dividend shifts out of acc_lo
    // to the left into the partial remainder in acc_hi while quotient bits
    // fill in from the bottom.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_diff  = div_shift[XLEN-1:0] - opnd_q;
        last_iter = (cnt_q == CNT_W'(MULDIV_ITERS - 1));

        lo_fix = neg_q ? negate(acc_lo) : acc_lo;
        // Negating the 64-bit product: the upper half only receives the +1
        // carry when the lower half is all zeros.
        if (!neg_q)
            hi_fix = acc_hi;
        else if (op_q[2])
            hi_fix = negate(acc_hi);
        else
            hi_fix = ~acc_hi + XLEN'(acc_lo == '0);
        sel_lo  = (op_q == MUL) || (op_q == DIV) || (op_q == DIVU);
        fix_res = sel_lo ? lo_fix : hi_fix;
    end

    // Next-state logic; a kill overrides everything, including a new op.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (i_valid) state_nxt = special ? DONE : CALC;
            CALC:    if (last_iter) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    if (!i_hold) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (i_kill)
            state_nxt = IDLE;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_nxt;
    end

    // Operand capture, iteration datapath and result register. Operands are
    // only looked at in IDLE; for a multiply opnd_q holds |a| as the addend,
    // for a divide it holds |b| as the divisor.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q     <= MUL;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            opnd_q   <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid && !i_kill) begin
                        op_q   <= op_in;
                        neg_q  <= res_neg;
                        cnt_q  <= '0;
                        acc_hi <= '0;
                        opnd_q <= i_op[2] ? b_mag : a_mag;
                        acc_lo <= i_op[2] ? a_mag : b_mag;
                        if (special)
                            result_q <= special_res;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (op_q[2]) begin
                        acc_hi <= div_ge ? div_diff : div_shift[XLEN-1:0];
                        acc_lo <= {acc_lo[XLEN-2:0], div_ge};
                    end else begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[XLEN-1:1]};
                    end
                end
                FIX: begin
                    if (!i_kill)
                        result_q <= fix_res;
                end
                default: ;
            endcase
        end
    end

    assign o_done   = (state_q == DONE);
    assign o_stall  = i_valid & (state_q != DONE);
    assign o_result = result_q;

endmodule
